// File: rtl/hart_issue_sched_pkg.sv
// hart_issue_sched_pkg: shared hart-control widths, scheduler FSM encodings and helpers.
// Defines HART_ID_W/HART_STATE_W/HART_ID_B/HART_STATE_B and HSCHED_S_* unless the including build already has them.
`ifndef HART_CTRL_H
`define HART_CTRL_H
`define HART_ID_W       2
`define HART_STATE_W    4
`define HART_ID_B       1
`define HART_STATE_B    3
`define HSCHED_S_IDLE   2'd0
`define HSCHED_S_RR     2'd1
`define HSCHED_S_PRIM   2'd2
`endif

package hart_issue_sched_pkg;
    typedef enum logic [1:0] {
        S_IDLE = `HSCHED_S_IDLE,
`ifdef HART_PRIM_PRIO_EN
        S_PRIM = `HSCHED_S_PRIM,
`endif
        S_RR   = `HSCHED_S_RR
    } hsched_state_e;

    function automatic logic [`HART_ID_B:0] first_hid(input logic [`HART_STATE_B:0] m);
        first_hid = '0;
        for (int i = `HART_STATE_B; i >= 0; i--)
            if (m[i]) first_hid = i[`HART_ID_B:0];
    endfunction
endpackage

// File: rtl/decoder_n.sv
// decoder_n: N-to-2^N one-hot decoder with enable; all-zero output when disabled.
module decoder_n #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [(1<<N)-1:0] dec
);
    assign dec = {{((1 << N) - 1){1'b0}}, en} << sel;
endmodule

// File: rtl/hart_rr_pick.sv
// hart_rr_pick: rotating-priority search starting just after rr_ptr, wrapping back to rr_ptr itself.
module hart_rr_pick
    import hart_issue_sched_pkg::*;
(
    input  logic [`HART_STATE_B:0] mask,
    input  logic [`HART_ID_B:0]    rr_ptr,
    output logic                   found,
    output logic [`HART_ID_B:0]    pick_hid
);
    logic [`HART_ID_B:0] h;

    // Scan farthest-first so the nearest candidate is the last one to win.
    always_comb begin
        found    = 1'b0;
        pick_hid = rr_ptr;
        h        = '0;
        for (int i = `HART_STATE_W; i >= 1; i--) begin
            h = rr_ptr + i[`HART_ID_B:0];
            if (mask[h]) begin
                found    = 1'b1;
                pick_hid = h;
            end
        end
    end
endmodule

// File: rtl/hart_issue_sched.sv
// hart_issue_sched: registered hart issue scheduler (redirect > stall > idle > primary slot > round-robin).
// Optional primary-hart interleave slot enabled by defining HART_PRIM_PRIO_EN.
module hart_issue_sched
    import hart_issue_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`HART_STATE_B:0] acti_hstate,
    input  logic [`HART_STATE_B:0] prim_hstate,
    input  logic                   if_stall,
    input  logic                   redirect,
    input  logic [`HART_ID_B:0]    redirect_hid,
    output logic                   issue_valid,
    output logic [`HART_ID_B:0]    issue_hid,
    output logic [`HART_STATE_B:0] issue_hstate
);
    hsched_state_e       state, state_nx;
    logic [`HART_ID_B:0] rr_ptr, rr_nx, hid_nx, pick_hid;
    logic                valid_nx, found, redir_ok;

    hart_rr_pick u_pick (
        .mask     (acti_hstate),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .pick_hid (pick_hid)
    );

    assign redir_ok = redirect & acti_hstate[redirect_hid];

`ifdef HART_PRIM_PRIO_EN
    logic [`HART_STATE_B:0] prim_act;
    logic                   prim_go;
    assign prim_act = prim_hstate & acti_hstate;
    // Skip the primary slot when the primary hart was just issued, so it never goes back-to-back.
    assign prim_go  = state == S_PRIM && prim_act != '0 && first_hid(prim_act) != issue_hid;
`else
    logic unused_prim;
    assign unused_prim = ^prim_hstate;
`endif

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        valid_nx = issue_valid;
        hid_nx   = issue_hid;
        if (redir_ok) begin
            state_nx = S_RR;
            rr_nx    = redirect_hid;
            valid_nx = 1'b1;
            hid_nx   = redirect_hid;
        end else if (!if_stall) begin
            if (!found) begin
                state_nx = S_IDLE;
                valid_nx = 1'b0;
`ifdef HART_PRIM_PRIO_EN
            end else if (prim_go) begin
                state_nx = S_RR;
                valid_nx = 1'b1;
                hid_nx   = first_hid(prim_act);
`endif
            end else begin
`ifdef HART_PRIM_PRIO_EN
                state_nx = S_PRIM;
`else
                state_nx = S_RR;
`endif
                rr_nx    = pick_hid;
                valid_nx = 1'b1;
                hid_nx   = pick_hid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '1;
            issue_valid <= 1'b0;
            issue_hid   <= '0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_nx;
            issue_valid <= valid_nx;
            issue_hid   <= hid_nx;
        end
    end

    decoder_n #(.N(`HART_ID_W)) u_dec (
        .sel (issue_hid),
        .en  (issue_valid),
        .dec (issue_hstate)
    );
endmodule

// File: tb/tb_hart_issue_sched.sv
// tb_hart_issue_sched: directed and random stimulus against a rule-level model of the issue scheduler.
module tb_hart_issue_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] acti_hstate = '0;
    logic [3:0] prim_hstate = '0;
    logic       if_stall = 1'b0;
    logic       redirect = 1'b0;
    logic [1:0] redirect_hid = '0;
    logic       issue_valid;
    logic [1:0] issue_hid;
    logic [3:0] issue_hstate;

`ifdef HART_PRIM_PRIO_EN
    localparam bit PRIM_EN = 1'b1;
`else
    localparam bit PRIM_EN = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    bit m_valid;
    int m_hid, m_rr;
    bit m_prim_slot;

    hart_issue_sched dut (
        .clk          (clk),
        .rst          (rst),
        .acti_hstate  (acti_hstate),
        .prim_hstate  (prim_hstate),
        .if_stall     (if_stall),
        .redirect     (redirect),
        .redirect_hid (redirect_hid),
        .issue_valid  (issue_valid),
        .issue_hid    (issue_hid),
        .issue_hstate (issue_hstate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 8'(issue_valid), 8'(m_valid));
        chk({tag, ".hid"}, 8'(issue_hid), 8'(m_hid));
        chk({tag, ".hstate"}, 8'(issue_hstate), m_valid ? 8'(1 << m_hid) : 8'h0);
    endtask

    // Reset asserted together with redirect and stall: reset must win.
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_hid = 2'd2;
        if_stall = 1'b1;
        acti_hstate = 4'hf;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_hid = 0;
        m_rr = 3;
        m_prim_slot = 1'b0;
        check_outputs("reset");
        rst = 1'b0;
        redirect = 1'b0;
        if_stall = 1'b0;
        acti_hstate = '0;
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] p, input logic s,
                        input logic r, input logic [1:0] rh, input int exp_hid, input string tag);
        int pa, ph;
        acti_hstate = a;
        prim_hstate = p;
        if_stall = s;
        redirect = r;
        redirect_hid = rh;
        pa = PRIM_EN ? int'(p & a) : 0;
        ph = 0;
        for (int i = 3; i >= 0; i--) if (pa[i]) ph = i;
        if (r && a[rh]) begin
            m_valid = 1'b1;
            m_hid = int'(rh);
            m_rr = int'(rh);
            m_prim_slot = 1'b0;
        end else if (s) begin
        end else if (a == 4'h0) begin
            m_valid = 1'b0;
            m_prim_slot = 1'b0;
        end else if (m_prim_slot && pa != 0 && ph != m_hid) begin
            m_valid = 1'b1;
            m_hid = ph;
            m_prim_slot = 1'b0;
        end else begin
            for (int k = 4; k >= 1; k--) if (a[(m_rr + k) % 4]) m_hid = (m_rr + k) % 4;
            m_rr = m_hid;
            m_valid = 1'b1;
            m_prim_slot = PRIM_EN;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (exp_hid >= 0) begin
            chk({tag, ".spec_valid"}, 8'(issue_valid), 8'h1);
            chk({tag, ".spec_hid"}, 8'(issue_hid), 8'(exp_hid));
        end
    endtask

    int seq030[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        logic [3:0] ra, rp;
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 0, "single");

        do_reset();
        for (int i = 0; i < 6; i++) step(4'b1011, 4'b0000, 1'b0, 1'b0, 2'd0, seq030[i], "rr1011");

        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, 4'b0100, 1'b0, 1'b0, 2'd0, -1, "prim");

        do_reset();
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 0, "stall_pre");
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 1, "stall_pre");
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1, "stall");
        step(4'b0101, 4'b0000, 1'b1, 1'b0, 2'd0, 1, "stall");
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 1, "stall");
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 2, "stall_rel");

        step(4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 3, "redir_ok");
        step(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 0, "redir_next");
        step(4'b0001, 4'b0000, 1'b1, 1'b1, 2'd3, 0, "redir_ign");
        step(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd3, 0, "redir_ign_ns");

        do_reset();
        step(4'b0110, 4'b0000, 1'b0, 1'b0, 2'd0, 1, "idle_pre");
        step(4'b0110, 4'b0000, 1'b0, 1'b0, 2'd0, 2, "idle_pre");
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, -1, "idle");
        chk("idle.valid0", 8'(issue_valid), 8'h0);
        chk("idle.hstate0", 8'(issue_hstate), 8'h0);
        step(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 2, "idle_exit");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            ra = 4'($urandom_range(0, 15));
            rp = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
            step(ra, rp, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 2'($urandom_range(0, 3)), -1, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
